uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers. It accepts one byte per grant over a valid/ready handshake. Optionally it prefixes the byte with a channel-ID header byte, and it sequences the transmitter via a tx_start/tx_done pulse handshake. A watchdog aborts a transfer when the transmitter never completes.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter, with header byte and watchdog
module uart_tx_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter bit          HDR_EN   = 1'b1,
  parameter logic [7:0]  HDR_BASE = 8'hA0,
  parameter logic [15:0] TIMEOUT  = 16'd50000,
  localparam int         CW       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [CW-1:0]        grant_id,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    WAIT_HDR,
    SEND_DATA,
    WAIT_DATA
  } state_t;

  state_t               state;
  logic [CW-1:0]        last_grant;
  logic [7:0]           data_reg;
  logic [15:0]          wdog;

  logic                 win_found;
  logic [CW-1:0]        win_idx;
  logic [NUM_REQ-1:0]   win_vec;
  logic [7:0]           win_data;
  int                   cand;

  logic [7:0]           hdr_byte;
  logic                 done_ok;
  logic                 wdog_expired;

  // Rotating-priority search: the channel after the last one served is checked first
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_vec   = '0;
    win_data  = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found     = 1'b1;
        win_idx       = CW'(cand);
        win_vec[cand] = 1'b1;
        win_data      = req_data[8*cand +: 8];
      end
    end
  end

  // Accept is only offered while idle; one byte per grant
  assign req_ready    = (state == IDLE) ? win_vec : '0;
  assign busy         = (state != IDLE);
  assign hdr_byte     = HDR_BASE | 8'(grant_id);
  // A done pulse coincident with the load pulse belongs to an earlier frame
  assign done_ok      = tx_done && !tx_start;
  // The final waiting cycle; a done arriving here still wins over the abort
  assign wdog_expired = (wdog == TIMEOUT - 16'd1);

  // Transfer sequencer: grant, optional header, payload, each gated by tx_done or the watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      last_grant  <= CW'(NUM_REQ - 1);
      wdog        <= 16'd0;
      data_reg    <= 8'h00;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            data_reg <= win_data;
            grant_id <= win_idx;
            state    <= HDR_EN ? SEND_HDR : SEND_DATA;
          end
        end
        SEND_HDR: begin
          tx_start <= 1'b1;
          tx_data  <= hdr_byte;
          wdog     <= 16'd0;
          state    <= WAIT_HDR;
        end
        SEND_DATA: begin
          tx_start <= 1'b1;
          tx_data  <= data_reg;
          wdog     <= 16'd0;
          state    <= WAIT_DATA;
        end
        WAIT_HDR: begin
          if (done_ok) begin
            state <= SEND_DATA;
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        WAIT_DATA: begin
          if (done_ok) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a timestamp reference model
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int T  = 20;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          busy;
  logic [1:0]    grant_id;
  logic          timeout_err;

  logic [NR-1:0] v1;
  logic [8*NR-1:0] d1;
  logic [NR-1:0] ready1;
  logic          start1;
  logic [7:0]    txd1;
  logic          done1;
  logic          busy1;
  logic [1:0]    gid1;
  logic          err1;

  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .TIMEOUT(16'd20)) dut_nohdr (
    .clk(clk), .reset(reset), .req_valid(v1), .req_data(d1), .req_ready(ready1),
    .tx_start(start1), .tx_data(txd1), .tx_done(done1), .busy(busy1), .grant_id(gid1),
    .timeout_err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL sim_timeout bound expired");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = -1;

  // observations of the most recent sampled cycle
  logic [NR-1:0] obs_ready, obs_valid;
  logic          obs_start, obs_busy, obs_err;
  logic [7:0]    obs_txd;
  logic [1:0]    obs_gid;
  int            start_cyc = 0;
  int            err_cyc   = 0;
  int            err_cnt   = 0;
  logic [NR-1:0] obs_ready1;
  logic          obs_busy1;
  int            s1_cnt    = 0;
  logic [7:0]    s1_data   = 8'h00;

  // reference model: a transfer is described by its channel, its byte and
  // the cycle at which the next load pulse is due
  bit        m_busy    = 0;
  int        m_last    = NR - 1;
  int        m_gid     = 0;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] m_txd    = 8'h00;
  bit        m_hdr     = 0;
  bit        m_err     = 0;
  int        m_start_at = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s bound expired at cyc=%0d", name, cyc);
  endtask

  task automatic check();
    logic [NR-1:0] e_ready;
    int            g;
    bit            found;
    cyc++;
    obs_ready  = req_ready;
    obs_valid  = req_valid;
    obs_start  = tx_start;
    obs_txd    = tx_data;
    obs_busy   = busy;
    obs_gid    = grant_id;
    obs_err    = timeout_err;
    obs_ready1 = ready1;
    obs_busy1  = busy1;
    if (obs_start) start_cyc = cyc;
    if (obs_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (start1) begin
      s1_cnt++;
      s1_data = txd1;
    end

    e_ready = '0;
    found   = 0;
    g       = 0;
    if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int ch;
        ch = (m_last + k) % NR;
        if (!found && req_valid[ch]) begin
          found = 1;
          g = ch;
          e_ready[ch] = 1'b1;
        end
      end
    end

    cmp("m_ready", 32'(obs_ready), 32'(e_ready));
    cmp("m_tx_start", 32'(obs_start), 32'(m_busy && (cyc == m_start_at)));
    cmp("m_tx_data", 32'(obs_txd), 32'(m_txd));
    cmp("m_busy", 32'(obs_busy), 32'(m_busy));
    cmp("m_grant_id", 32'(obs_gid), 32'(m_gid));
    cmp("m_timeout_err", 32'(obs_err), 32'(m_err));

    if (reset) begin
      m_busy = 0; m_last = NR - 1; m_gid = 0; m_txd = 8'h00; m_err = 0; m_hdr = 0;
    end else begin
      m_err = 0;
      if (m_busy && (cyc + 1 == m_start_at))
        m_txd = m_hdr ? (8'hA0 | 8'(m_gid)) : m_data;
      if (!m_busy) begin
        if (found) begin
          m_busy = 1; m_gid = g; m_data = req_data[8*g +: 8]; m_hdr = 1; m_start_at = cyc + 2;
        end
      end else if (cyc >= m_start_at) begin
        if (tx_done && (cyc != m_start_at)) begin
          if (m_hdr) begin
            m_hdr = 0;
            m_start_at = cyc + 2;
          end else begin
            m_busy = 0;
            m_last = m_gid;
          end
        end else if (cyc == m_start_at + T - 1) begin
          m_err = 1; m_busy = 0; m_last = m_gid;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input string name, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (obs_start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) expire(name);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int s;
  int e0;
  int cd;
  bit td;
  logic [NR-1:0] acc;

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
    v1 = '0; d1 = '0; done1 = 1'b0;
    #1;
    step();
    step();
    reset = 1'b0;
    cmp("rst_busy", 32'(obs_busy), 32'd0);
    cmp("rst_tx_start", 32'(obs_start), 32'd0);
    cmp("rst_tx_data", 32'(obs_txd), 32'h00);
    cmp("rst_grant_id", 32'(obs_gid), 32'd0);
    cmp("rst_timeout_err", 32'(obs_err), 32'd0);

    // single request with header
    req_valid = 4'b0100; req_data[23:16] = 8'h5A;
    step();
    cmp("t1_ready", 32'(obs_ready), 32'b0100);
    req_valid = '0;
    wait_start("t1_hdr", 8);
    cmp("t1_hdr_byte", 32'(obs_txd), 32'hA2);
    step(); step();
    pulse_done();
    wait_start("t1_data", 8);
    cmp("t1_data_byte", 32'(obs_txd), 32'h5A);
    pulse_done();
    step();
    cmp("t1_busy_end", 32'(obs_busy), 32'd0);
    cmp("t1_grant_id", 32'(obs_gid), 32'd2);

    // all four held: strict rotation
    do_reset();
    req_valid = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      wait_start("t2_hdr", 8);
      cmp("t2_hdr_byte", 32'(obs_txd), 32'hA0 + 32'(i % 4));
      pulse_done();
      wait_start("t2_data", 8);
      cmp("t2_data_byte", 32'(obs_txd), 32'h10 + 32'(i % 4));
      pulse_done();
    end
    req_valid = '0;
    step();

    // watchdog abort on the header wait
    do_reset();
    step();
    req_valid = 4'b0010; req_data[15:8] = 8'h77;
    step();
    cmp("t3_ready", 32'(obs_ready), 32'b0010);
    req_valid = 4'b0100; req_data[23:16] = 8'h88;
    wait_start("t3_hdr", 8);
    cmp("t3_hdr_byte", 32'(obs_txd), 32'hA1);
    s = start_cyc;
    e0 = err_cnt;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs_err) break;
    end
    if (err_cnt == e0) expire("t3_timeout");
    else begin
      cmp("t3_err_delay", 32'(err_cyc - s), 32'd20);
      cmp("t3_next_ready", 32'(obs_ready), 32'b0100);
    end
    req_valid = '0;
    wait_start("t3_hdr2", 8);
    cmp("t3_hdr2_byte", 32'(obs_txd), 32'hA2);
    pulse_done();
    wait_start("t3_data2", 8);
    cmp("t3_data2_byte", 32'(obs_txd), 32'h88);
    pulse_done();
    step();

    // tx_done boundaries
    do_reset();
    req_valid = 4'b0001; req_data[7:0] = 8'h42;
    step();
    req_valid = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    cmp("t4_start_coincide", 32'(obs_start), 32'd1);
    s = cyc;
    step(); step();
    cmp("t4_still_busy", 32'(obs_busy), 32'd1);
    e0 = err_cnt;
    while (cyc + 1 < s + T - 1) step();
    pulse_done();
    wait_start("t4_data", 8);
    cmp("t4_data_byte", 32'(obs_txd), 32'h42);
    pulse_done();
    cmp("t4_no_err", 32'(err_cnt), 32'(e0));
    step();
    pulse_done();
    step();
    cmp("t4_idle_done", 32'(obs_busy), 32'd0);

    // reset while waiting for the payload to finish
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'h99;
    step();
    req_valid = '0;
    wait_start("t5_hdr", 8);
    pulse_done();
    wait_start("t5_data", 8);
    step();
    reset = 1'b1; req_valid = 4'b1111;
    step();
    reset = 1'b0;
    step();
    cmp("t5_busy", 32'(obs_busy), 32'd0);
    cmp("t5_tx_start", 32'(obs_start), 32'd0);
    cmp("t5_tx_data", 32'(obs_txd), 32'h00);
    cmp("t5_ready", 32'(obs_ready), 32'b0001);
    req_valid = '0;
    wait_start("t5_hdr2", 8);
    cmp("t5_hdr2_byte", 32'(obs_txd), 32'hA0);
    pulse_done();
    wait_start("t5_data2", 8);
    pulse_done();
    step();

    // payload-only instance
    v1 = 4'b1000; d1[31:24] = 8'h3C;
    e0 = s1_cnt;
    step();
    cmp("t6_ready", 32'(obs_ready1), 32'b1000);
    v1 = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s1_cnt != e0) break;
    end
    if (s1_cnt == e0) expire("t6_start");
    cmp("t6_data_byte", 32'(s1_data), 32'h3C);
    done1 = 1'b1;
    step();
    done1 = 1'b0;
    step(); step(); step(); step();
    cmp("t6_start_count", 32'(s1_cnt - e0), 32'd1);
    cmp("t6_busy_end", 32'(obs_busy1), 32'd0);

    // randomized traffic against the model
    do_reset();
    cd = -1;
    for (int n = 0; n < 3000; n++) begin
      step();
      acc = obs_valid & obs_ready;
      for (int ch = 0; ch < NR; ch++) begin
        if (acc[ch]) begin
          req_valid[ch] = 1'($urandom_range(1, 0));
          req_data[8*ch +: 8] = 8'($urandom);
        end else if (req_valid[ch]) begin
          if ($urandom_range(31, 0) == 0) req_valid[ch] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          req_valid[ch] = 1'b1;
          req_data[8*ch +: 8] = 8'($urandom);
        end
      end
      td = 0;
      if (obs_start) begin
        int r;
        r = int'($urandom_range(99, 0));
        if (r < 80) cd = int'($urandom_range(6, 1));
        else if (r < 92) cd = T - 1;
        else cd = -1;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) td = 1;
      end
      if ($urandom_range(29, 0) == 0) td = 1;
      tx_done = td;
      reset = ($urandom_range(599, 0) == 0);
    end
    reset = 1'b0;
    tx_done = 1'b0;
    req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
